// File: rtl/lsu.sv
// Load/store unit: one byte/halfword access at a time over a valid/grant/rvalid
// data-memory port, with load extension, pipeline stall and error reporting.
module lsu #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned RD_W    = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            load_en_i,
    input  logic            store_en_i,
    input  logic            size_i,
    input  logic            unsigned_i,
    input  logic [15:0]     addr_i,
    input  logic [15:0]     store_data_i,
    input  logic [RD_W-1:0] rd_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [15:0]     mem_addr_o,
    output logic [1:0]      mem_be_o,
    output logic [15:0]     mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [15:0]     mem_rdata_i,
    output logic            wb_valid_o,
    output logic [RD_W-1:0] wb_rd_o,
    output logic [15:0]     wb_data_o,
    output logic            stall_o,
    output logic            err_o,
    output logic [1:0]      err_code_o
);
    localparam int unsigned DW      = 16;
    localparam int unsigned CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERR} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [DW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     sdata_q, sdata_d;
    logic              size_q, size_d;
    logic              uns_q, uns_d;
    logic              we_q, we_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DW-1:0]     wb_data_q, wb_data_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;

    logic              accept;
    logic              to_hit;
    logic [7:0]        lane;
    logic [DW-1:0]     load_ext;

    assign accept = (state_q == S_IDLE) && req_valid_i;
    assign to_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));

    // State register and all datapath flops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            err_code_q <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            size_q     <= 1'b0;
            uns_q      <= 1'b0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_code_q <= err_code_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    // Next state, timeout counter and error code
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_code_d = err_code_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    cnt_d = '0;
                    if (load_en_i == store_en_i) begin
                        state_d    = S_ERR;
                        err_code_d = 2'b11;
                    end else if (size_i && addr_i[0]) begin
                        state_d    = S_ERR;
                        err_code_d = 2'b01;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ, S_WAIT: begin
                if ((state_q == S_REQ) ? mem_gnt_i : mem_rvalid_i) begin
                    state_d = ((state_q == S_REQ) && !we_q) ? S_WAIT : S_IDLE;
                end else if (to_hit) begin
                    state_d    = S_ERR;
                    err_code_d = 2'b10;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch and load writeback capture
    always_comb begin
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        size_d     = size_q;
        uns_d      = uns_q;
        we_d       = we_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        lane       = addr_q[0] ? mem_rdata_i[15:8] : mem_rdata_i[7:0];
        if (size_q) begin
            load_ext = mem_rdata_i;
        end else if (uns_q) begin
            load_ext = {8'h00, lane};
        end else begin
            load_ext = {{8{lane[7]}}, lane};
        end
        if (accept) begin
            addr_d  = addr_i;
            sdata_d = store_data_i;
            size_d  = size_i;
            uns_d   = unsigned_i;
            we_d    = store_en_i;
            rd_d    = rd_i;
        end
        if ((state_q == S_WAIT) && mem_rvalid_i) begin
            wb_valid_d = 1'b1;
            wb_data_d  = load_ext;
            wb_rd_d    = rd_q;
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        stall_o     = (state_q != S_IDLE);
        mem_req_o   = (state_q == S_REQ);
        err_o       = (state_q == S_ERR);
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = 2'b00;
        mem_wdata_o = '0;
        if (state_q == S_REQ) begin
            mem_we_o   = we_q;
            mem_addr_o = {addr_q[15:1], 1'b0};
            mem_be_o   = size_q ? 2'b11 : (addr_q[0] ? 2'b10 : 2'b01);
            if (we_q) begin
                mem_wdata_o = size_q ? sdata_q : {sdata_q[7:0], sdata_q[7:0]};
            end
        end
        wb_valid_o = wb_valid_q;
        wb_data_o  = wb_data_q;
        wb_rd_o    = wb_rd_q;
        err_code_o = err_code_q;
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a vector table of single accesses plus hand-written
// sequences for delayed grant, timeout, simultaneous events and reset mid-access.
module tb_lsu;
    localparam int unsigned RD_W = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid, req_ready, load_en, store_en, size, uns;
    logic [15:0]     addr, store_data;
    logic [RD_W-1:0] rd;
    logic            mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [15:0]     mem_addr, mem_wdata, mem_rdata;
    logic [1:0]      mem_be;
    logic            wb_valid, stall, err;
    logic [RD_W-1:0] wb_rd;
    logic [15:0]     wb_data;
    logic [1:0]      err_code;

    int checks = 0;
    int errors = 0;

    lsu #(.TIMEOUT(4), .RD_W(RD_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .load_en_i(load_en), .store_en_i(store_en),
        .size_i(size), .unsigned_i(uns),
        .addr_i(addr), .store_data_i(store_data), .rd_i(rd),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .stall_o(stall), .err_o(err), .err_code_o(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            ld, st, sz, un;
        logic [15:0]     a, sd, rdata;
        logic [RD_W-1:0] r;
        logic [1:0]      ecode;
        logic [15:0]     eaddr;
        logic [1:0]      ebe;
        logic [15:0]     ewdata, ewb;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_valid = 1'b0; load_en = 1'b0; store_en = 1'b0; size = 1'b0; uns = 1'b0;
        addr = '0; store_data = '0; rd = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic present(input logic ld, input logic st, input logic sz, input logic un,
                           input logic [15:0] a, input logic [15:0] sd, input logic [RD_W-1:0] r);
        req_valid = 1'b1; load_en = ld; store_en = st; size = sz; uns = un;
        addr = a; store_data = sd; rd = r;
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic sz, input logic un,
                                input logic [15:0] a, input logic [15:0] sd, input logic [15:0] rdata,
                                input logic [RD_W-1:0] r, input logic [1:0] ecode,
                                input logic [15:0] eaddr, input logic [1:0] ebe,
                                input logic [15:0] ewdata, input logic [15:0] ewb);
        vec_t v;
        v.ld = ld; v.st = st; v.sz = sz; v.un = un; v.a = a; v.sd = sd; v.rdata = rdata;
        v.r = r; v.ecode = ecode; v.eaddr = eaddr; v.ebe = ebe; v.ewdata = ewdata; v.ewb = ewb;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        chk($sformatf("v%0d ready_t0", idx), 16'(req_ready), 16'd1);
        present(v.ld, v.st, v.sz, v.un, v.a, v.sd, v.r);
        tick;
        req_valid = 1'b0; load_en = 1'b0; store_en = 1'b0;
        chk($sformatf("v%0d stall_t1", idx), 16'(stall), 16'd1);
        if (v.ecode != 2'b00) begin
            chk($sformatf("v%0d no_req", idx), 16'(mem_req), 16'd0);
            chk($sformatf("v%0d err", idx), 16'(err), 16'd1);
            chk($sformatf("v%0d err_code", idx), 16'(err_code), 16'(v.ecode));
            tick;
            chk($sformatf("v%0d err_drop", idx), 16'(err), 16'd0);
            chk($sformatf("v%0d ready_after_err", idx), 16'(req_ready), 16'd1);
        end else begin
            chk($sformatf("v%0d mem_req", idx), 16'(mem_req), 16'd1);
            chk($sformatf("v%0d mem_we", idx), 16'(mem_we), 16'(v.st));
            chk($sformatf("v%0d mem_addr", idx), mem_addr, v.eaddr);
            chk($sformatf("v%0d mem_be", idx), 16'(mem_be), 16'(v.ebe));
            if (v.st) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.ewdata);
            mem_gnt = 1'b1;
            tick;
            mem_gnt = 1'b0;
            chk($sformatf("v%0d req_drop", idx), 16'(mem_req), 16'd0);
            if (v.st) begin
                chk($sformatf("v%0d st_ready", idx), 16'(req_ready), 16'd1);
                chk($sformatf("v%0d st_stall", idx), 16'(stall), 16'd0);
            end else begin
                chk($sformatf("v%0d ld_wait_stall", idx), 16'(stall), 16'd1);
                mem_rvalid = 1'b1; mem_rdata = v.rdata;
                tick;
                mem_rvalid = 1'b0; mem_rdata = '0;
                chk($sformatf("v%0d wb_valid", idx), 16'(wb_valid), 16'd1);
                chk($sformatf("v%0d wb_data", idx), wb_data, v.ewb);
                chk($sformatf("v%0d wb_rd", idx), 16'(wb_rd), 16'(v.r));
                chk($sformatf("v%0d ld_ready", idx), 16'(req_ready), 16'd1);
                tick;
                chk($sformatf("v%0d wb_pulse", idx), 16'(wb_valid), 16'd0);
            end
        end
    endtask

    vec_t vecs[11];

    initial begin
        // ld st sz un addr sdata rdata rd ecode eaddr be ewdata ewb
        vecs[0]  = mk(1, 0, 1, 0, 16'h0104, 16'h0000, 16'hBEEF, 4'd5, 2'b00, 16'h0104, 2'b11, 16'h0000, 16'hBEEF);
        vecs[1]  = mk(1, 0, 0, 0, 16'h0101, 16'h0000, 16'h8012, 4'd3, 2'b00, 16'h0100, 2'b10, 16'h0000, 16'hFF80);
        vecs[2]  = mk(1, 0, 0, 1, 16'h0101, 16'h0000, 16'h8012, 4'd7, 2'b00, 16'h0100, 2'b10, 16'h0000, 16'h0080);
        vecs[3]  = mk(1, 0, 0, 0, 16'h0100, 16'h0000, 16'h8012, 4'd9, 2'b00, 16'h0100, 2'b01, 16'h0000, 16'h0012);
        vecs[4]  = mk(1, 0, 0, 0, 16'h0100, 16'h0000, 16'h80F3, 4'd1, 2'b00, 16'h0100, 2'b01, 16'h0000, 16'hFFF3);
        vecs[5]  = mk(0, 1, 1, 0, 16'h0200, 16'h1234, 16'h0000, 4'd0, 2'b00, 16'h0200, 2'b11, 16'h1234, 16'h0000);
        vecs[6]  = mk(0, 1, 0, 0, 16'h0202, 16'h12A5, 16'h0000, 4'd0, 2'b00, 16'h0202, 2'b01, 16'hA5A5, 16'h0000);
        vecs[7]  = mk(1, 0, 1, 0, 16'h0011, 16'h0000, 16'h0000, 4'd2, 2'b01, 16'h0000, 2'b00, 16'h0000, 16'h0000);
        vecs[8]  = mk(1, 1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 4'd2, 2'b11, 16'h0000, 2'b00, 16'h0000, 16'h0000);
        vecs[9]  = mk(0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 4'd2, 2'b11, 16'h0000, 2'b00, 16'h0000, 16'h0000);
        vecs[10] = mk(0, 1, 1, 0, 16'h0013, 16'h5555, 16'h0000, 4'd0, 2'b01, 16'h0000, 2'b00, 16'h0000, 16'h0000);

        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_ready", 16'(req_ready), 16'd1);
        chk("rst_stall", 16'(stall), 16'd0);
        chk("rst_req", 16'(mem_req), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_code", 16'(err_code), 16'd0);
        chk("rst_wb", 16'(wb_valid), 16'd0);
        tick;
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Byte store with grant delayed three cycles
        present(0, 1, 0, 0, 16'h0203, 16'h12A5, 4'd0);
        tick;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("dly%0d req", c), 16'(mem_req), 16'd1);
            chk($sformatf("dly%0d we", c), 16'(mem_we), 16'd1);
            chk($sformatf("dly%0d addr", c), mem_addr, 16'h0202);
            chk($sformatf("dly%0d be", c), 16'(mem_be), 16'b10);
            chk($sformatf("dly%0d wdata", c), mem_wdata, 16'hA5A5);
            chk($sformatf("dly%0d stall", c), 16'(stall), 16'd1);
            tick;
        end
        mem_gnt = 1'b1;
        chk("dly_gnt req", 16'(mem_req), 16'd1);
        tick;
        mem_gnt = 1'b0;
        chk("dly ready", 16'(req_ready), 16'd1);
        chk("dly stall", 16'(stall), 16'd0);

        // Timeout: grant never comes
        present(1, 0, 1, 0, 16'h0300, 16'h0000, 4'd4);
        tick;
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("to%0d req", c), 16'(mem_req), 16'd1);
            chk($sformatf("to%0d err", c), 16'(err), 16'd0);
            tick;
        end
        chk("to req_drop", 16'(mem_req), 16'd0);
        chk("to err", 16'(err), 16'd1);
        chk("to code", 16'(err_code), 16'b10);
        tick;
        chk("to err_pulse", 16'(err), 16'd0);
        chk("to ready", 16'(req_ready), 16'd1);
        mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 16'h1234;
        tick;
        idle_inputs();
        chk("late wb", 16'(wb_valid), 16'd0);
        chk("late req", 16'(mem_req), 16'd0);
        chk("late ready", 16'(req_ready), 16'd1);

        // rvalid on the final timeout cycle wins, then back-to-back accept
        present(1, 0, 1, 0, 16'h0400, 16'h0000, 4'd6);
        tick;
        idle_inputs();
        mem_gnt = 1'b1;
        tick;
        mem_gnt = 1'b0;
        for (int c = 0; c < 3; c++) tick;
        chk("sim wait err", 16'(err), 16'd0);
        chk("sim wait stall", 16'(stall), 16'd1);
        mem_rvalid = 1'b1; mem_rdata = 16'hCAFE;
        tick;
        idle_inputs();
        chk("sim wb_valid", 16'(wb_valid), 16'd1);
        chk("sim wb_data", wb_data, 16'hCAFE);
        chk("sim wb_rd", 16'(wb_rd), 16'd6);
        chk("sim no_err", 16'(err), 16'd0);
        chk("sim code_held", 16'(err_code), 16'b10);
        present(0, 1, 1, 0, 16'h0500, 16'h7777, 4'd0);
        tick;
        idle_inputs();
        chk("b2b req", 16'(mem_req), 16'd1);
        chk("b2b wdata", mem_wdata, 16'h7777);
        mem_gnt = 1'b1;
        tick;
        mem_gnt = 1'b0;
        chk("b2b ready", 16'(req_ready), 16'd1);

        // Reset while waiting for read data
        present(1, 0, 1, 0, 16'h0600, 16'h0000, 4'd8);
        tick;
        idle_inputs();
        mem_gnt = 1'b1;
        tick;
        mem_gnt = 1'b0;
        chk("rmid stall_pre", 16'(stall), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid ready", 16'(req_ready), 16'd1);
        chk("rmid stall", 16'(stall), 16'd0);
        chk("rmid code", 16'(err_code), 16'd0);
        tick;
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        tick;
        idle_inputs();
        chk("rmid no_wb", 16'(wb_valid), 16'd0);
        chk("rmid no_err", 16'(err), 16'd0);
        tick;
        chk("rmid no_wb2", 16'(wb_valid), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
